// File: rtl/c157x_track_loader_if.sv
// SD block-request bus between the track loader (master) and the host SD controller (slave).
interface c157x_track_loader_if;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, sd_blk_cnt, sd_rd, sd_wr, input sd_ack);
    modport slave  (input sd_lba, sd_blk_cnt, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/c157x_track_loader.sv
// Track-image transfer sequencer: moves whole tracks between the SD image and the 157x track buffer.
// Optional: define C157X_LOADER_IDLE_FLUSH_EN to write back a dirty track after 2^24 quiet idle cycles.
module c157x_track_loader #(
    parameter int          TRACK_BUF_LEN = 8192,
    parameter int          NUM_TRACKS    = 84,
    parameter logic [15:0] SETTLE_CYCLES = 16'd20000
) (
    input  logic                        sd_clk,
    input  logic                        reset,
    input  logic                        img_mounted,
    input  logic                        img_readonly,
    input  logic [31:0]                 img_size,
    input  logic [6:0]                  track,
    input  logic                        side,
    input  logic                        dirty_set,
    c157x_track_loader_if.master        sd,
    output logic                        sd_busy,
    output logic [7:0]                  loaded_track
);
    localparam int         SECT     = TRACK_BUF_LEN / 512;
    localparam logic [7:0] NO_TRACK = 8'hFF;

    typedef enum logic [2:0] {NODISK, IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
    state_t state, state_nxt;

    logic [31:0] lba_q, lba_nxt;
    logic [31:0] size_q, size_nxt;
    logic [15:0] settle_cnt, settle_nxt;
    logic [7:0]  loaded_nxt, rd_tgt, prev_tgt, cur_tgt;
    logic        rd_q, rd_nxt, wr_q, wr_nxt, busy_nxt;
    logic        dirty, dirty_nxt, ro, ro_nxt;
    logic        keep_dirty, keep_nxt, drain, drain_nxt, ack_d;
    logic        ack_rise, ack_fall, dset_ok, rd_start, wr_start;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
    logic [23:0] idle_cnt, idle_nxt;
    logic        flush, flush_nxt;
`endif

    function automatic logic [31:0] track_index(input logic [7:0] t);
        return (t[7] ? 32'(NUM_TRACKS) : 32'd0) + {25'd0, t[6:0]};
    endfunction

    function automatic logic [31:0] lba_of(input logic [7:0] t);
        return track_index(t) * 32'(SECT);
    endfunction

    // A track is transferable only if its slot exists and all its sectors lie inside the image.
    function automatic logic in_image(input logic [7:0] t, input logic [31:0] size);
        return (track_index(t) < 32'(2 * NUM_TRACKS)) &&
               (lba_of(t) + 32'(SECT) <= (size >> 9));
    endfunction

    assign cur_tgt       = {side, track};
    assign ack_rise      = sd.sd_ack & ~ack_d;
    assign ack_fall      = ~sd.sd_ack & ack_d;
    assign dset_ok       = dirty_set & ~ro & (loaded_track != NO_TRACK);
    assign sd.sd_lba     = lba_q;
    assign sd.sd_rd      = rd_q;
    assign sd.sd_wr      = wr_q;
    assign sd.sd_blk_cnt = 6'(SECT - 1);

    always_comb begin
        state_nxt  = state;
        lba_nxt    = lba_q;
        rd_nxt     = rd_q;
        wr_nxt     = wr_q;
        busy_nxt   = sd_busy;
        loaded_nxt = loaded_track;
        dirty_nxt  = dirty | dset_ok;
        keep_nxt   = keep_dirty | dset_ok;
        ro_nxt     = ro;
        size_nxt   = size_q;
        drain_nxt  = drain;
        settle_nxt = 16'd0;
        rd_start   = 1'b0;
        wr_start   = 1'b0;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
        idle_nxt   = 24'd0;
        flush_nxt  = flush;
`endif
        // An aborted transfer keeps the head stage frozen until the host lets go of ack.
        if (drain && !sd.sd_ack) begin
            drain_nxt = 1'b0;
            busy_nxt  = 1'b0;
        end

        if (img_mounted) begin
            ro_nxt     = img_readonly;
            dirty_nxt  = 1'b0;
            loaded_nxt = NO_TRACK;
            size_nxt   = img_size;
            rd_nxt     = 1'b0;
            wr_nxt     = 1'b0;
            drain_nxt  = sd_busy & sd.sd_ack;
            busy_nxt   = sd_busy & sd.sd_ack;
            state_nxt  = (img_size == 32'd0) ? NODISK : IDLE;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
            flush_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                NODISK: ;
                IDLE: begin
                    if (cur_tgt == prev_tgt && cur_tgt != loaded_track && !drain) begin
                        if (settle_cnt == SETTLE_CYCLES) begin
                            if (dirty && in_image(loaded_track, size_q)) wr_start = 1'b1;
                            else                                          rd_start = 1'b1;
                        end else begin
                            settle_nxt = settle_cnt + 16'd1;
                        end
                    end
`ifdef C157X_LOADER_IDLE_FLUSH_EN
                    else if (dirty && !drain && !dset_ok && cur_tgt == loaded_track &&
                             in_image(loaded_track, size_q)) begin
                        if (idle_cnt == 24'hFFFFFF) begin
                            wr_start  = 1'b1;
                            flush_nxt = 1'b1;
                        end else begin
                            idle_nxt = idle_cnt + 24'd1;
                        end
                    end
`endif
                end
                WR_REQ: if (ack_rise) begin
                    wr_nxt    = 1'b0;
                    state_nxt = WR_WAIT;
                end
                WR_WAIT: if (ack_fall) begin
                    // Writes that raced the write-back are not in the image yet.
                    dirty_nxt = keep_dirty | dset_ok;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
                    if (flush) begin
                        flush_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else
`endif
                    rd_start = 1'b1;
                end
                RD_REQ: if (ack_rise) begin
                    rd_nxt    = 1'b0;
                    state_nxt = RD_WAIT;
                end
                RD_WAIT: if (ack_fall) begin
                    loaded_nxt = rd_tgt;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
                default: state_nxt = NODISK;
            endcase

            if (wr_start) begin
                state_nxt = WR_REQ;
                wr_nxt    = 1'b1;
                busy_nxt  = 1'b1;
                lba_nxt   = lba_of(loaded_track);
                keep_nxt  = dset_ok;
            end
            // Out-of-image targets are "loaded" without a transfer; the head stage sees no data.
            if (rd_start) begin
                if (in_image(cur_tgt, size_q)) begin
                    state_nxt = RD_REQ;
                    rd_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    lba_nxt   = lba_of(cur_tgt);
                end else begin
                    state_nxt  = IDLE;
                    busy_nxt   = 1'b0;
                    loaded_nxt = cur_tgt;
                end
            end
        end
    end

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state        <= NODISK;
            lba_q        <= 32'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            sd_busy      <= 1'b0;
            loaded_track <= NO_TRACK;
            dirty        <= 1'b0;
            keep_dirty   <= 1'b0;
            ro           <= 1'b0;
            size_q       <= 32'd0;
            drain        <= 1'b0;
            settle_cnt   <= 16'd0;
            ack_d        <= 1'b0;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
            idle_cnt     <= 24'd0;
            flush        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            lba_q        <= lba_nxt;
            rd_q         <= rd_nxt;
            wr_q         <= wr_nxt;
            sd_busy      <= busy_nxt;
            loaded_track <= loaded_nxt;
            dirty        <= dirty_nxt;
            keep_dirty   <= keep_nxt;
            ro           <= ro_nxt;
            size_q       <= size_nxt;
            drain        <= drain_nxt;
            settle_cnt   <= settle_nxt;
            ack_d        <= sd.sd_ack;
`ifdef C157X_LOADER_IDLE_FLUSH_EN
            idle_cnt     <= idle_nxt;
            flush        <= flush_nxt;
`endif
        end
    end

    always_ff @(posedge sd_clk) begin
        prev_tgt <= cur_tgt;
        if (rd_start) rd_tgt <= cur_tgt;
    end

endmodule

// File: tb/tb_c157x_track_loader.sv
// Bench for c157x_track_loader: directed scenarios plus randomized traffic against a transaction-level model.
module tb_c157x_track_loader;
    localparam int          NT     = 84;
    localparam int          SECT   = 16;
    localparam int          SETTLE = 200;
    localparam logic [31:0] FULL   = 32'd1398784;

    logic        sd_clk = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [31:0] img_size = 32'd0;
    logic [6:0]  track = 7'd0;
    logic        side = 1'b0;
    logic        dirty_set = 1'b0;
    logic        sd_busy;
    logic [7:0]  loaded_track;

    int checks = 0;
    int errors = 0;

    c157x_track_loader_if sd_if ();

    c157x_track_loader #(
        .TRACK_BUF_LEN(8192),
        .NUM_TRACKS   (NT),
        .SETTLE_CYCLES(16'(SETTLE))
    ) dut (
        .sd_clk      (sd_clk),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .img_size    (img_size),
        .track       (track),
        .side        (side),
        .dirty_set   (dirty_set),
        .sd          (sd_if.master),
        .sd_busy     (sd_busy),
        .loaded_track(loaded_track)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: whole-track transactions derived from the loader rules.
    logic [7:0]  m_loaded, m_prev, m_tgt;
    logic [31:0] m_size, m_lba;
    logic        m_dirty, m_ro, m_disk, m_req, m_busy, m_keep, m_drain, m_ackp;
    int          m_stable, m_xfer;   // m_xfer: 0 none, 1 write-back, 2 read

    function automatic int m_index(input logic [7:0] t);
        return int'(t[7]) * NT + int'(t[6:0]);
    endfunction

    function automatic logic m_inr(input logic [7:0] t);
        return (m_index(t) < 2 * NT) && (longint'(m_index(t) * SECT + SECT) <= longint'(m_size / 512));
    endfunction

    task automatic m_read(input logic [7:0] t);
        if (!m_inr(t)) begin
            m_loaded = t;
            m_busy   = 1'b0;
        end else begin
            m_xfer = 2;
            m_req  = 1'b1;
            m_busy = 1'b1;
            m_lba  = 32'(m_index(t) * SECT);
            m_tgt  = t;
        end
    endtask

    task automatic model_step();
        logic [7:0] tgt;
        logic ack, ar, af, dok, old_dirty, was_drain;
        tgt = {side, track};
        ack = sd_if.sd_ack;
        if (reset) begin
            m_loaded = 8'hFF; m_dirty = 1'b0; m_ro = 1'b0; m_size = 32'd0; m_disk = 1'b0;
            m_stable = 0; m_xfer = 0; m_req = 1'b0; m_busy = 1'b0; m_lba = 32'd0;
            m_keep = 1'b0; m_drain = 1'b0; m_ackp = 1'b0;
        end else begin
            ar = ack && !m_ackp;
            af = !ack && m_ackp;
            dok = dirty_set && !m_ro && m_loaded != 8'hFF;
            old_dirty = m_dirty;
            was_drain = m_drain;
            if (img_mounted) begin
                m_ro = img_readonly; m_dirty = 1'b0; m_loaded = 8'hFF; m_size = img_size;
                m_disk = (img_size != 0); m_req = 1'b0; m_xfer = 0; m_stable = 0;
                m_drain = m_busy && ack;
                m_busy = m_drain;
            end else begin
                if (dok) m_dirty = 1'b1;
                m_keep = m_keep || dok;
                if (m_drain && !ack) begin
                    m_drain = 1'b0;
                    m_busy  = 1'b0;
                end
                if (m_xfer == 0) begin
                    if (!m_disk || tgt != m_prev || tgt == m_loaded || was_drain) m_stable = 0;
                    else if (m_stable == SETTLE) begin
                        m_stable = 0;
                        if (old_dirty && m_inr(m_loaded)) begin
                            m_xfer = 1; m_req = 1'b1; m_busy = 1'b1;
                            m_lba = 32'(m_index(m_loaded) * SECT);
                            m_keep = dok;
                        end else m_read(tgt);
                    end else m_stable++;
                end else if (m_req) begin
                    if (ar) m_req = 1'b0;
                end else if (af) begin
                    if (m_xfer == 1) begin
                        m_dirty = m_keep;
                        m_xfer = 0;
                        m_read(tgt);
                    end else begin
                        m_loaded = m_tgt;
                        m_busy = 1'b0;
                        m_xfer = 0;
                    end
                end
            end
            m_ackp = ack;
        end
        m_prev = tgt;
    endtask

    task automatic compare();
        if (reset) return;
        check("sd_rd", 64'(sd_if.sd_rd), 64'(m_req && m_xfer == 2));
        check("sd_wr", 64'(sd_if.sd_wr), 64'(m_req && m_xfer == 1));
        check("sd_busy", 64'(sd_busy), 64'(m_busy));
        check("loaded_track", 64'(loaded_track), 64'(m_loaded));
        check("sd_blk_cnt", 64'(sd_if.sd_blk_cnt), 64'(SECT - 1));
        if (m_req) check("sd_lba", 64'(sd_if.sd_lba), 64'(m_lba));
    endtask

    initial forever begin
        @(posedge sd_clk);
        model_step();
    end

    initial forever begin
        @(negedge sd_clk);
        compare();
    end

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic mount(input logic ro, input logic [31:0] size);
        img_readonly = ro;
        img_size = size;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
    endtask

    task automatic pulse_dirty();
        dirty_set = 1'b1;
        tick();
        dirty_set = 1'b0;
    endtask

    task automatic wait_req(output int n, input int limit);
        n = 0;
        while (!(sd_if.sd_rd || sd_if.sd_wr) && n < limit) begin
            tick();
            n++;
        end
        check("request_seen", 64'(sd_if.sd_rd || sd_if.sd_wr), 64'd1);
    endtask

    task automatic serve(input int hold);
        sd_if.sd_ack = 1'b1;
        repeat (hold) tick();
        sd_if.sd_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic xfer(input string name, input logic exp_wr, input logic [31:0] exp_lba);
        int n;
        wait_req(n, 4 * SETTLE + 100);
        check({name, "_is_write"}, 64'(sd_if.sd_wr), 64'(exp_wr));
        check({name, "_lba"}, 64'(sd_if.sd_lba), 64'(exp_lba));
        serve($urandom_range(5, 20));
    endtask

    initial begin
        int n, cnt, hold, dly;
        sd_if.sd_ack = 1'b0;
        repeat (3) tick();
        check("reset_rd", 64'(sd_if.sd_rd), 64'd0);
        check("reset_wr", 64'(sd_if.sd_wr), 64'd0);
        check("reset_busy", 64'(sd_busy), 64'd0);
        check("reset_lba", 64'(sd_if.sd_lba), 64'd0);
        check("reset_loaded", 64'(loaded_track), 64'hFF);
        reset = 1'b0;
        tick();

        // First load after mount: exact settle latency, busy falls one cycle after ack.
        mount(1'b0, FULL);
        wait_req(n, 4 * SETTLE);
        check("settle_latency", 64'(n), 64'(SETTLE + 1));
        check("t1_rd", 64'(sd_if.sd_rd), 64'd1);
        check("t1_lba", 64'(sd_if.sd_lba), 64'd0);
        check("t1_blk_cnt", 64'(sd_if.sd_blk_cnt), 64'd15);
        sd_if.sd_ack = 1'b1;
        repeat (100) tick();
        check("t1_rd_dropped", 64'(sd_if.sd_rd), 64'd0);
        check("t1_busy_during_ack", 64'(sd_busy), 64'd1);
        sd_if.sd_ack = 1'b0;
        @(negedge sd_clk);
        check("t1_busy_same_cycle", 64'(sd_busy), 64'd1);
        tick();
        check("t1_busy_fall", 64'(sd_busy), 64'd0);
        check("t1_loaded", 64'(loaded_track), 64'h00);

        // Dirty write-back then read; next step is clean.
        pulse_dirty();
        track = 7'd2;
        xfer("wb_t0", 1'b1, 32'd0);
        xfer("rd_t2", 1'b0, 32'd32);
        track = 7'd5;
        xfer("rd_t5_clean", 1'b0, 32'd80);

        // Read-only image never writes back.
        mount(1'b1, FULL);
        track = 7'd4;
        xfer("ro_rd_t4", 1'b0, 32'd64);
        repeat (3) pulse_dirty();
        track = 7'd6;
        xfer("ro_rd_t6", 1'b0, 32'd96);

        side = 1'b1;
        track = 7'd3;
        xfer("side1_t3", 1'b0, 32'd1392);

        // Track toggling faster than the settle time produces no request.
        mount(1'b0, FULL);
        side = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            track = (i % 2 == 1) ? 7'd10 : 7'd11;
            repeat (50) begin
                tick();
                if (sd_if.sd_rd || sd_if.sd_wr) cnt++;
            end
        end
        check("toggle_no_request", 64'(cnt), 64'd0);
        track = 7'd12;
        wait_req(n, 4 * SETTLE);
        check("step_latency", 64'(n), 64'(SETTLE + 2));
        check("t12_lba", 64'(sd_if.sd_lba), 64'd192);
        serve(10);
        cnt = 0;
        repeat (3 * SETTLE) begin
            tick();
            if (sd_if.sd_rd || sd_if.sd_wr) cnt++;
        end
        check("single_read_only", 64'(cnt), 64'd0);

        // Mount during an active read aborts it and discards dirty data.
        track = 7'd20;
        wait_req(n, 4 * SETTLE);
        sd_if.sd_ack = 1'b1;
        repeat (5) tick();
        pulse_dirty();
        mount(1'b0, FULL);
        check("abort_rd_low", 64'(sd_if.sd_rd), 64'd0);
        check("abort_loaded", 64'(loaded_track), 64'hFF);
        check("abort_busy_held", 64'(sd_busy), 64'd1);
        repeat (10) tick();
        check("abort_busy_still", 64'(sd_busy), 64'd1);
        sd_if.sd_ack = 1'b0;
        tick();
        check("abort_busy_released", 64'(sd_busy), 64'd0);
        wait_req(n, 4 * SETTLE);
        check("reload_latency", 64'(n), 64'(SETTLE + 1));
        check("reload_not_write", 64'(sd_if.sd_wr), 64'd0);
        check("reload_lba", 64'(sd_if.sd_lba), 64'd320);
        serve(8);

        // Randomized traffic: steps, dirty pulses, remounts and a host with random latency.
        hold = 0;
        dly = 0;
        for (int c = 0; c < 20000; c++) begin
            dirty_set = ($urandom_range(0, 19) == 0);
            img_mounted = 1'b0;
            if ($urandom_range(0, 2999) == 0) begin
                img_mounted = 1'b1;
                img_readonly = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       img_size = 32'd0;
                    1:       img_size = 32'd327680;
                    default: img_size = FULL;
                endcase
            end
            if ($urandom_range(0, 399) == 0) begin
                side = 1'($urandom_range(0, 1));
                track = 7'($urandom_range(0, 99));
            end
            if (sd_if.sd_ack) begin
                if (hold == 0) sd_if.sd_ack = 1'b0;
                else hold--;
            end else if (sd_if.sd_rd || sd_if.sd_wr) begin
                if (dly == 0) begin
                    sd_if.sd_ack = 1'b1;
                    hold = $urandom_range(2, 30);
                    dly = $urandom_range(0, 4);
                end else dly--;
            end
            tick();
        end
        dirty_set = 1'b0;
        img_mounted = 1'b0;
        sd_if.sd_ack = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
